// File: rtl/wb_cmd_master.sv
//-----------------------------------------------------------------------------
// wb_cmd_master
//
// Turns single commands from a valid/ready command channel into Wishbone
// classic bus accesses and returns one response per command on a
// valid/ready response channel. A command is a write, a single read or
// (optionally) a poll: the same address is read repeatedly until the masked
// read data equals the masked expected value, with a bounded attempt count.
// Each bus access is bounded by an ack timeout.
//
// Configuration macro:
//   WB_CMD_MASTER_POLL_EN  defined   -> poll commands supported (mask
//                                       compare, GAP state, attempt counter,
//                                       status 10 on exhaustion)
//                          undefined -> cmd_poll_i / cmd_mask_i ignored; every
//                                       non-write is a plain single read
//
// Parameters:
//   TIMEOUT_CYCLES  cycles an access waits for wb_ack_i (0 = wait forever)
//   POLL_MAX        read attempts per poll command (0 = unbounded)
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake (ready only when idle)
//   cmd_we_i, cmd_poll_i         write / poll-read select
//   cmd_adr_i, cmd_dat_i         address, write data or poll expected value
//   cmd_mask_i, cmd_sel_i        poll compare mask, byte selects
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_data_o, rsp_err_o        read data, status (00 ok, 01 timeout,
//                                10 poll exhausted)
//   busy_o                       high whenever not idle
//   wb_*                         Wishbone classic master port
//-----------------------------------------------------------------------------
module wb_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned POLL_MAX       = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic        cmd_poll_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   input  logic [31:0] cmd_mask_i,
   input  logic [3:0]  cmd_sel_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic [1:0]  rsp_err_o,
   output logic        busy_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i
);

   // Timeout counter is wide enough to hold TIMEOUT_CYCLES and saturates.
   localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 2);
   localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_TMO = 2'b01;

`ifdef WB_CMD_MASTER_POLL_EN
   localparam logic [1:0] ERR_POLL = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;
`endif

   state_t        state_r;
   state_t        state_d;

   // Latched command
   logic [31:0]   adr_r;
   logic [31:0]   dat_r;
   logic [3:0]    sel_r;
   logic          we_r;

   logic [TW-1:0] tmo_cnt_r;
   logic          tmo_hit_s;
   logic          accept_s;

   // Registered outputs and their next values
   logic          cmd_ready_r;
   logic          cmd_ready_d;
   logic          busy_r;
   logic          busy_d;
   logic          cyc_r;
   logic          cyc_d;
   logic          we_out_r;
   logic          we_out_d;
   logic          rsp_valid_r;
   logic          rsp_valid_d;
   logic [31:0]   rsp_data_r;
   logic [31:0]   rsp_data_d;
   logic [1:0]    rsp_err_r;
   logic [1:0]    rsp_err_d;

   // cmd_ready_o is high exactly in IDLE, so IDLE plus valid is the handshake.
   assign accept_s  = (state_r == ST_IDLE) && cmd_valid_i;
   assign tmo_hit_s = TMO_EN && (tmo_cnt_r == TMO_LAST);

`ifdef WB_CMD_MASTER_POLL_EN
   localparam int unsigned   PW        = $clog2(POLL_MAX + 2);
   localparam bit            PMAX_EN   = (POLL_MAX != 0);
   localparam logic [PW-1:0] POLL_LAST = PW'((POLL_MAX > 0) ? (POLL_MAX - 1) : 0);

   logic          poll_r;
   logic [31:0]   mask_r;
   logic [PW-1:0] poll_cnt_r;    // completed mismatching reads of this command
   logic          match_s;
   logic          poll_last_s;
   logic          poll_retry_s;

   // Only bits selected by the mask take part in the compare.
   assign match_s      = ((wb_dat_i ^ dat_r) & mask_r) == 32'h0000_0000;
   assign poll_last_s  = PMAX_EN && (poll_cnt_r == POLL_LAST);
   assign poll_retry_s = poll_r && !match_s && !poll_last_s;
`else
   logic unused_poll_s;

   assign unused_poll_s = cmd_poll_i ^ (^cmd_mask_i);
`endif

   // State register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            // An ack in the same cycle as the timeout still completes the access.
            if (wb_ack_i) begin
`ifdef WB_CMD_MASTER_POLL_EN
               if (poll_retry_s) begin
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_RSP;
               end
`else
               state_d = ST_RSP;
`endif
            end else if (tmo_hit_s) begin
               state_d = ST_RSP;
            end else begin
               state_d = ST_REQ;
            end
         end
`ifdef WB_CMD_MASTER_POLL_EN
         ST_GAP: begin
            // One idle bus cycle between poll reads.
            state_d = ST_REQ;
         end
`endif
         ST_RSP: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RSP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: next values of every registered output
   always_comb begin
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      cyc_d       = (state_d == ST_REQ);
      // On the accept edge the latched we is not yet valid; use the input.
      if (accept_s) begin
         we_out_d = cmd_we_i;
      end else begin
         we_out_d = cyc_d & we_r;
      end

      rsp_valid_d = rsp_valid_r;
      rsp_data_d  = rsp_data_r;
      rsp_err_d   = rsp_err_r;
      if ((state_r == ST_REQ) && (state_d == ST_RSP)) begin
         rsp_valid_d = 1'b1;
         if (wb_ack_i) begin
            if (we_r) begin
               rsp_data_d = 32'h0000_0000;
            end else begin
               rsp_data_d = wb_dat_i;
            end
`ifdef WB_CMD_MASTER_POLL_EN
            // Leaving REQ on a mismatching poll read means attempts ran out.
            if (poll_r && !match_s) begin
               rsp_err_d = ERR_POLL;
            end else begin
               rsp_err_d = ERR_OK;
            end
`else
            rsp_err_d = ERR_OK;
`endif
         end else begin
            rsp_data_d = 32'h0000_0000;
            rsp_err_d  = ERR_TMO;
         end
      end else if (state_d == ST_IDLE) begin
         rsp_valid_d = 1'b0;
         rsp_data_d  = 32'h0000_0000;
         rsp_err_d   = ERR_OK;
      end else begin
         // Response held stable while waiting for rsp_ready_i.
         rsp_valid_d = rsp_valid_r;
      end
   end

   // Output registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         cyc_r       <= 1'b0;
         we_out_r    <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= 32'h0000_0000;
         rsp_err_r   <= 2'b00;
      end else begin
         cmd_ready_r <= cmd_ready_d;
         busy_r      <= busy_d;
         cyc_r       <= cyc_d;
         we_out_r    <= we_out_d;
         rsp_valid_r <= rsp_valid_d;
         rsp_data_r  <= rsp_data_d;
         rsp_err_r   <= rsp_err_d;
      end
   end

   // Command latch, loaded on the accept handshake
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         adr_r <= 32'h0000_0000;
         dat_r <= 32'h0000_0000;
         sel_r <= 4'h0;
         we_r  <= 1'b0;
      end else if (accept_s) begin
         adr_r <= cmd_adr_i;
         dat_r <= cmd_dat_i;
         sel_r <= cmd_sel_i;
         we_r  <= cmd_we_i;
      end
   end

   // Ack timeout counter: zero outside REQ so every entry starts fresh
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tmo_cnt_r <= '0;
      end else if (state_r != ST_REQ) begin
         tmo_cnt_r <= '0;
      end else if (tmo_cnt_r != '1) begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
      end
   end

`ifdef WB_CMD_MASTER_POLL_EN
   // Poll command latch, loaded on the accept handshake
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         poll_r <= 1'b0;
         mask_r <= 32'h0000_0000;
      end else if (accept_s) begin
         // Poll only applies to reads.
         poll_r <= cmd_poll_i & ~cmd_we_i;
         mask_r <= cmd_mask_i;
      end
   end

   // Poll attempt counter: counts each mismatching read that leads to a retry
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         poll_cnt_r <= '0;
      end else if (accept_s) begin
         poll_cnt_r <= '0;
      end else if ((state_r == ST_REQ) && (state_d == ST_GAP) && (poll_cnt_r != '1)) begin
         poll_cnt_r <= poll_cnt_r + PW'(1'b1);
      end
   end
`endif

   assign cmd_ready_o = cmd_ready_r;
   assign busy_o      = busy_r;
   assign rsp_valid_o = rsp_valid_r;
   assign rsp_data_o  = rsp_data_r;
   assign rsp_err_o   = rsp_err_r;
   assign wb_cyc_o    = cyc_r;
   assign wb_stb_o    = cyc_r;
   assign wb_we_o     = we_out_r;
   assign wb_adr_o    = adr_r;
   assign wb_dat_o    = dat_r;
   assign wb_sel_o    = sel_r;

endmodule

// File: tb/tb_wb_cmd_master.sv
`timescale 1ns/1ps
module tb_wb_cmd_master;

   localparam int unsigned TMO  = 8;
   localparam int unsigned PMAX = 4;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_we_i;
   logic        cmd_poll_i;
   logic [31:0] cmd_adr_i;
   logic [31:0] cmd_dat_i;
   logic [31:0] cmd_mask_i;
   logic [3:0]  cmd_sel_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_data_o;
   logic [1:0]  rsp_err_o;
   logic        busy_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_cmd_master #(
      .TIMEOUT_CYCLES (TMO),
      .POLL_MAX       (PMAX)
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we_i),
      .cmd_poll_i  (cmd_poll_i),
      .cmd_adr_i   (cmd_adr_i),
      .cmd_dat_i   (cmd_dat_i),
      .cmd_mask_i  (cmd_mask_i),
      .cmd_sel_i   (cmd_sel_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .busy_o      (busy_o),
      .wb_adr_o    (wb_adr_o),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_sel_o    (wb_sel_o),
      .wb_we_o     (wb_we_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_ack_i    (wb_ack_i)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  err;
   } rsp_t;

   typedef struct packed {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
   } bus_t;

   rsp_t rsp_q[$];
   bus_t bus_q[$];
   logic [31:0] rd_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic exp_rsp(input logic [31:0] data, input logic [1:0] err);
      rsp_t r;
      r.data = data;
      r.err  = err;
      rsp_q.push_back(r);
   endtask

   task automatic exp_bus(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
      bus_t b;
      b.adr = adr;
      b.we  = we;
      b.dat = dat;
      b.sel = sel;
      bus_q.push_back(b);
   endtask

   // Wishbone slave model: acks after slave_delay stb cycles, one-cycle ack,
   // checks each acked access against the expected-access queue.
   int          slave_delay = 1;
   bit          slave_noack = 1'b0;
   logic [31:0] rd_default  = 32'h0000_0000;
   int          wcnt        = 0;
   bus_t        bexp;

   always @(negedge wb_clk_i) begin
      if (wb_ack_i) begin
         wb_ack_i = 1'b0;
      end else if (wb_cyc_o && wb_stb_o && !slave_noack) begin
         if (wcnt >= slave_delay) begin
            wcnt     = 0;
            wb_ack_i = 1'b1;
            if (rd_q.size() > 0) wb_dat_i = rd_q.pop_front();
            else                 wb_dat_i = rd_default;
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_access: got adr 0x%08h we %b, expected no access", wb_adr_o, wb_we_o);
            end else begin
               bexp = bus_q.pop_front();
               chk("bus_adr", wb_adr_o, bexp.adr);
               chk1("bus_we", wb_we_o, bexp.we);
               chk("bus_sel", {28'h0, wb_sel_o}, {28'h0, bexp.sel});
               if (bexp.we) chk("bus_dat", wb_dat_o, bexp.dat);
            end
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   // Bus activity tracker: cyc pulses, pulse lengths and gaps between them
   int cyc_rises = 0;
   int cur_len   = 0;
   int last_len  = 0;
   int gap_len   = 0;
   int last_gap  = 0;
   bit cyc_prev  = 1'b0;

   always @(negedge wb_clk_i) begin
      if (wb_cyc_o) begin
         if (!cyc_prev) begin
            cyc_rises++;
            last_gap = gap_len;
            cur_len  = 0;
         end
         cur_len++;
      end else begin
         if (cyc_prev) begin
            last_len = cur_len;
            gap_len  = 0;
         end
         gap_len++;
      end
      cyc_prev = wb_cyc_o;
      if (!wb_rst_i) begin
         chk1("stb_eq_cyc", wb_stb_o, wb_cyc_o);
         chk1("we_only_in_cyc", wb_we_o & ~wb_cyc_o, 1'b0);
         chk1("busy_vs_ready", busy_o, ~cmd_ready_o);
      end
   end

   // Response monitor: pops the scoreboard on every response handshake
   rsp_t rexp;

   always @(negedge wb_clk_i) begin
      if (!wb_rst_i && rsp_valid_o && rsp_ready_i) begin
         if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got data 0x%08h err %0d, expected no response", rsp_data_o, rsp_err_o);
         end else begin
            rexp = rsp_q.pop_front();
            chk("rsp_data", rsp_data_o, rexp.data);
            chk("rsp_err", {30'h0, rsp_err_o}, {30'h0, rexp.err});
         end
      end
   end

   task automatic issue(input logic we, input logic poll, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [31:0] mask, input logic [3:0] sel);
      int n = 0;
      cmd_we_i    = we;
      cmd_poll_i  = poll;
      cmd_adr_i   = adr;
      cmd_dat_i   = dat;
      cmd_mask_i  = mask;
      cmd_sel_i   = sel;
      cmd_valid_i = 1'b1;
      while (!cmd_ready_o && n < 300) begin
         @(posedge wb_clk_i); #1;
         n++;
      end
      if (!cmd_ready_o) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: cmd_ready_o got 0 expected 1");
         cmd_valid_i = 1'b0;
      end else begin
         @(posedge wb_clk_i); #1;
         cmd_valid_i = 1'b0;
         chk1("cyc_after_accept", wb_cyc_o, 1'b1);
         chk1("ready_after_accept", cmd_ready_o, 1'b0);
         chk1("busy_after_accept", busy_o, 1'b1);
         chk1("we_after_accept", wb_we_o, we);
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((rsp_q.size() != 0 || !cmd_ready_o) && n < 300) begin
         @(posedge wb_clk_i); #1;
         n++;
      end
      chk1({name, "_done"}, (rsp_q.size() == 0) && cmd_ready_o, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int          base;
   int          n_reads;
   int          n;
   logic [31:0] hold_data;
   logic [1:0]  hold_err;

   initial begin
      wb_rst_i    = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_we_i    = 1'b0;
      cmd_poll_i  = 1'b0;
      cmd_adr_i   = 32'h0;
      cmd_dat_i   = 32'h0;
      cmd_mask_i  = 32'h0;
      cmd_sel_i   = 4'h0;
      rsp_ready_i = 1'b1;
      wb_dat_i    = 32'h0;
      wb_ack_i    = 1'b0;

      // Reset state
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk1("rst_cmd_ready", cmd_ready_o, 1'b1);
      chk1("rst_cyc", wb_cyc_o, 1'b0);
      chk1("rst_stb", wb_stb_o, 1'b0);
      chk1("rst_we", wb_we_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_rsp_data", rsp_data_o, 32'h0);
      chk("rst_rsp_err", {30'h0, rsp_err_o}, 32'h0);
      chk("rst_adr", wb_adr_o, 32'h0);
      chk("rst_sel", {28'h0, wb_sel_o}, 32'h0);
      wb_rst_i = 1'b0;
      repeat (2) @(posedge wb_clk_i);
      #1;

      // Write 0x1234 to 0x04, slave acks after one wait cycle
      base = cyc_rises;
      slave_delay = 1;
      exp_bus(32'h0000_0004, 1'b1, 32'h0000_1234, 4'hF);
      exp_rsp(32'h0000_0000, 2'b00);
      issue(1'b1, 1'b0, 32'h0000_0004, 32'h0000_1234, 32'h0, 4'hF);
      wait_done("wr");
      chk("wr_accesses", cyc_rises - base, 32'd1);

      // Read 0x08 then a queued read of 0x0C: two separate cyc pulses
      base = cyc_rises;
      rd_q.push_back(32'hDEAD_BEEF);
      rd_q.push_back(32'h0000_55AA);
      exp_bus(32'h0000_0008, 1'b0, 32'h0, 4'hF);
      exp_bus(32'h0000_000C, 1'b0, 32'h0, 4'h3);
      exp_rsp(32'hDEAD_BEEF, 2'b00);
      exp_rsp(32'h0000_55AA, 2'b00);
      issue(1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 4'hF);
      issue(1'b0, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 4'h3);
      wait_done("rd2");
      chk("rd2_accesses", cyc_rises - base, 32'd2);

      // Ack timeout: cyc held exactly TMO cycles, status 01, data 0
      slave_noack = 1'b1;
      exp_rsp(32'h0000_0000, 2'b01);
      issue(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 4'hF);
      wait_done("tmo");
      chk("tmo_cyc_len", last_len, 32'd8);
      slave_noack = 1'b0;

      // Poll 0x04 mask 3 expected 3; slave returns 1, 1, 3
      base = cyc_rises;
      slave_delay = 0;
`ifdef WB_CMD_MASTER_POLL_EN
      rd_q.push_back(32'h0000_0001);
      rd_q.push_back(32'h0000_0001);
      rd_q.push_back(32'h0000_0003);
      repeat (3) exp_bus(32'h0000_0004, 1'b0, 32'h0, 4'hF);
      exp_rsp(32'h0000_0003, 2'b00);
      issue(1'b0, 1'b1, 32'h0000_0004, 32'h0000_0003, 32'h0000_0003, 4'hF);
      wait_done("poll");
      chk("poll_accesses", cyc_rises - base, 32'd3);
      chk("poll_gap", last_gap, 32'd1);
`else
      rd_q.push_back(32'h0000_0001);
      exp_bus(32'h0000_0004, 1'b0, 32'h0, 4'hF);
      exp_rsp(32'h0000_0001, 2'b00);
      issue(1'b0, 1'b1, 32'h0000_0004, 32'h0000_0003, 32'h0000_0003, 4'hF);
      wait_done("poll");
      chk("poll_accesses", cyc_rises - base, 32'd1);
`endif

      // Response held with rsp_ready_i low for 5 cycles
      base = cyc_rises;
      rsp_ready_i = 1'b0;
`ifdef WB_CMD_MASTER_POLL_EN
      rd_default = 32'h0000_0001;
      repeat (4) exp_bus(32'h0000_0004, 1'b0, 32'h0, 4'hF);
      hold_data = 32'h0000_0001;
      hold_err  = 2'b10;
      n_reads   = 4;
`else
      rd_q.push_back(32'hCAFE_F00D);
      exp_bus(32'h0000_0004, 1'b0, 32'h0, 4'hF);
      hold_data = 32'hCAFE_F00D;
      hold_err  = 2'b00;
      n_reads   = 1;
`endif
      issue(1'b0, 1'b1, 32'h0000_0004, 32'h0000_0003, 32'h0000_0003, 4'hF);
      n = 0;
      while (!rsp_valid_o && n < 300) begin
         @(posedge wb_clk_i); #1;
         n++;
      end
      chk1("hold_valid_seen", rsp_valid_o, 1'b1);
      repeat (5) begin
         @(posedge wb_clk_i); #1;
         chk1("hold_valid", rsp_valid_o, 1'b1);
         chk("hold_data", rsp_data_o, hold_data);
         chk("hold_err", {30'h0, rsp_err_o}, {30'h0, hold_err});
         chk1("hold_ready_low", cmd_ready_o, 1'b0);
      end
      exp_rsp(hold_data, hold_err);
      rsp_ready_i = 1'b1;
      wait_done("hold");
      chk("hold_accesses", cyc_rises - base, n_reads);
      rd_default = 32'h0000_0000;

      // Reset asserted while an access waits for ack
      slave_noack = 1'b1;
      issue(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 4'hF);
      @(posedge wb_clk_i); #3;
      wb_rst_i = 1'b1;
      #1;
      chk1("arst_cyc", wb_cyc_o, 1'b0);
      chk1("arst_stb", wb_stb_o, 1'b0);
      chk1("arst_busy", busy_o, 1'b0);
      chk1("arst_ready", cmd_ready_o, 1'b1);
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b0;
      slave_noack = 1'b0;
      repeat (4) begin
         @(posedge wb_clk_i); #1;
         chk1("post_rst_valid", rsp_valid_o, 1'b0);
         chk1("post_rst_ready", cmd_ready_o, 1'b1);
         chk1("post_rst_cyc", wb_cyc_o, 1'b0);
      end

      // Normal write after reset recovery
      slave_delay = 2;
      exp_bus(32'h0000_0044, 1'b1, 32'hA5A5_0F0F, 4'h5);
      exp_rsp(32'h0000_0000, 2'b00);
      issue(1'b1, 1'b0, 32'h0000_0044, 32'hA5A5_0F0F, 32'h0, 4'h5);
      wait_done("wr2");

      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("rsp_q_empty", rsp_q.size(), 32'd0);
      chk("bus_q_empty", bus_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a single bus access waits for wb_ack_i.
REQ-002 Parameter POLL_MAX, default 1024: maximum read attempts per poll command.
REQ-003 wb_clk_i  in  1  the only clock; all logic on its rising edge.
REQ-004 wb_rst_i  in  1  reset; asynchronous, active-high.
REQ-005 cmd_valid_i / cmd_ready_o  in / out  1 / 1  command handshake; transfer when both are high on a clock edge.
REQ-006 cmd_we_i, cmd_poll_i  in  1 each  1 = write; 1 = poll-read (ignored when cmd_we_i = 1).
REQ-007 cmd_adr_i, cmd_dat_i, cmd_mask_i  in  32 each  address; write data or poll expected value; poll compare mask.
REQ-008 cmd_sel_i  in  4  byte selects.
REQ-009 rsp_valid_o / rsp_ready_i  out / in  1 / 1  response handshake.
REQ-010 rsp_data_o  out  32  read data (last read for poll, 0 for write).
REQ-011 rsp_err_o  out  2  status: 00 OK, 01 ack timeout, 10 poll exhausted.
REQ-012 busy_o  out  1  high in any state other than IDLE.
REQ-013 wb_adr_o, wb_dat_o  out  32 each  Wishbone classic master address and data.
REQ-014 wb_dat_i  in  32  Wishbone read data.
REQ-015 wb_sel_o  out  4  byte selects; wb_we_o, wb_cyc_o, wb_stb_o out 1 each; wb_ack_i in 1.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, GAP and RSP; all outputs SHALL be registered.
REQ-017 cmd_ready_o SHALL be high only in IDLE; a command accepted at edge T SHALL register adr/dat/sel/we/mask and drive wb_cyc_o = wb_stb_o = 1 from T+1 (state REQ).
REQ-018 In REQ, when wb_ack_i is sampled high at edge N, wb_dat_i SHALL be captured at N, and wb_cyc_o/wb_stb_o SHALL be low from N+1.
REQ-019 After a non-poll access completes, rsp_valid_o SHALL rise at N+1 with rsp_err_o = 00 (state RSP).
REQ-020 wb_ack_i SHALL be ignored outside REQ; slaves may hold ack one cycle after stb falls.
REQ-021 wb_cyc_o SHALL be low for at least one cycle between any two accesses.
REQ-022 The timeout counter SHALL clear on entry to REQ; if ack is absent for TIMEOUT_CYCLES cycles, cyc/stb SHALL drop and RSP SHALL be entered with rsp_err_o = 01 and rsp_data_o = 0.
REQ-023 Poll: after each read, if (data & mask) == (expected & mask), go to RSP with 00; otherwise go to GAP for one cycle, then REQ with the same address.
REQ-024 Poll attempts SHALL be counted, including the first; the POLL_MAX-th mismatching read SHALL give rsp_err_o = 10 with the last read data.
REQ-025 A timeout during poll SHALL end the command with 01 immediately.
REQ-026 rsp_valid_o, rsp_data_o and rsp_err_o SHALL be stable until rsp_ready_i is high; handshake at edge R SHALL return to IDLE with cmd_ready_o high from R+1.
REQ-027 wb_we_o SHALL equal the latched cmd_we_i while wb_cyc_o is high, and be 0 otherwise.
REQ-028 Counters SHALL saturate and never wrap; TIMEOUT_CYCLES = 0 SHALL mean no timeout.

Reset
REQ-029 While wb_rst_i is high, the FSM SHALL be IDLE, with all outputs 0 except cmd_ready_o = 1, and counters 0.
REQ-030 Reset asserted mid-transaction SHALL drop wb_cyc_o/wb_stb_o asynchronously and discard the command without a response.

Configuration
REQ-031 With WB_CMD_MASTER_POLL_EN defined, poll logic (mask compare, GAP, attempt counter, err 10) SHALL be present.
REQ-032 Without WB_CMD_MASTER_POLL_EN, cmd_poll_i SHALL be ignored (plain single read), GAP and the poll counter SHALL not exist, and err 10 SHALL never occur.

Verification
REQ-033 Write adr 0x04, dat 0x1234, sel 0xF, slave acks after 1 cycle -> one cyc/stb/we pulse with those values; rsp err 00, data 0.
REQ-034 Read adr 0x08, slave returns 0xDEADBEEF -> rsp_data_o 0xDEADBEEF, err 00; cyc low ≥1 cycle before the next queued command starts.
REQ-035 Slave never acks, TIMEOUT_CYCLES = 8 -> cyc drops after 8 REQ cycles; err 01, data 0.
REQ-036 Poll adr 0x04, mask 0x3, expected 0x3, slave returns 0x1 twice then 0x3 -> 3 reads with a 1-cycle GAP between each; err 00, data 0x3.
REQ-037 Poll never matches, POLL_MAX = 4 -> exactly 4 reads; err 10; rsp held 5 cycles with rsp_ready_i low, values unchanged.
REQ-038 wb_rst_i pulsed during REQ -> cyc/stb low immediately, no rsp_valid_o, cmd_ready_o = 1 after reset.
